// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - registered multi-cycle ALU with start/busy/done handshake, carry and zero flags
// Optional build macro: ALU_ROTATE_EN turns opcode 110 into rotate-right (co = last bit rotated out).
module alu_mc #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [2:0]       operation,
  output logic [WIDTH-1:0] result,
  output logic             co,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_FWD = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLL = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nx;

  // Multiply datapath: accumulator, left-shifting multiplicand, right-shifting multiplier
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [SHW-1:0]     cnt;
  logic [2*WIDTH-1:0] acc_step;

  // Single-cycle datapath
  logic [WIDTH-1:0] sc_result;
  logic             sc_co;
  logic [SHW-1:0]   amt;
  logic [WIDTH:0]   add_sum;

  logic accept;
  logic last_iter;

  // A request is only taken while idle; starts during a multiply are dropped
  assign accept    = start && (state == S_IDLE);
  assign last_iter = (state == S_MUL) && (cnt == SHW'(WIDTH - 1));
  assign amt       = data2[SHW-1:0];
  assign add_sum   = {1'b0, data1} + {1'b0, data2};
  assign acc_step  = acc + (mplier[0] ? mcand : '0);

  // State register: reset discards any multiply in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic: a multiply occupies exactly WIDTH iterations regardless of operands
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (accept && (operation == OP_MUL)) begin
          state_nx = S_MUL;
        end
      end
      S_MUL: begin
        if (last_iter) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // FSM outputs: busy tracks the multiply state directly so reset clears it at once
  always_comb begin
    busy = 1'b0;
    if (state == S_MUL) begin
      busy = 1'b1;
    end
  end

  // Single-cycle operation results, computed straight from the live operands at acceptance
  always_comb begin
`ifdef ALU_ROTATE_EN
    logic [2*WIDTH-1:0] rot;
    logic [SHW-1:0]     amt_m1;
    rot    = {data1, data1} >> amt;
    amt_m1 = amt - SHW'(1);
`endif
    sc_result = '0;
    sc_co     = 1'b0;
    case (operation)
      OP_FWD: sc_result = data2;
      OP_ADD: begin
        sc_result = add_sum[WIDTH-1:0];
        sc_co     = add_sum[WIDTH];
      end
      OP_AND: sc_result = data1 & data2;
      OP_OR:  sc_result = data1 | data2;
      OP_SUB: begin
        sc_result = data1 - data2;
        sc_co     = (data1 < data2);
      end
      OP_SLL: sc_result = data1 << amt;
      OP_SRL: begin
`ifdef ALU_ROTATE_EN
        // Rotating the doubled word right leaves the rotated value in the low half
        sc_result = rot[WIDTH-1:0];
        sc_co     = (amt != '0) ? data1[amt_m1] : 1'b0;
`else
        sc_result = data1 >> amt;
`endif
      end
      default: begin
        sc_result = '0;
        sc_co     = 1'b0;
      end
    endcase
  end

  // Result/flag registers and multiply iteration; done is a one-cycle pulse per completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result <= '0;
      co     <= 1'b0;
      zero   <= 1'b0;
      done   <= 1'b0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (operation == OP_MUL) begin
          acc    <= '0;
          mcand  <= {{WIDTH{1'b0}}, data1};
          mplier <= data2;
          cnt    <= '0;
        end else begin
          result <= sc_result;
          co     <= sc_co;
          zero   <= (sc_result == '0);
          done   <= 1'b1;
        end
      end else if (state == S_MUL) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + SHW'(1);
        if (last_iter) begin
          // acc_step already holds the full product on the final iteration
          result <= acc_step[WIDTH-1:0];
          co     <= |acc_step[2*WIDTH-1:WIDTH];
          zero   <= (acc_step[WIDTH-1:0] == '0);
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (8-bit and 16-bit instances)
module tb_alu_mc;

  logic        clk;
  logic        reset;

  logic        start;
  logic [7:0]  data1;
  logic [7:0]  data2;
  logic [2:0]  operation;
  logic [7:0]  result;
  logic        co;
  logic        zero;
  logic        busy;
  logic        done;

  logic        start16;
  logic [15:0] data1_16;
  logic [15:0] data2_16;
  logic [2:0]  operation16;
  logic [15:0] result16;
  logic        co16;
  logic        zero16;
  logic        busy16;
  logic        done16;

  int checks;
  int failures;

  alu_mc #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .data1(data1), .data2(data2),
    .operation(operation), .result(result), .co(co), .zero(zero),
    .busy(busy), .done(done)
  );

  alu_mc #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .data1(data1_16), .data2(data2_16),
    .operation(operation16), .result(result16), .co(co16), .zero(zero16),
    .busy(busy16), .done(done16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the opcode definitions
  task automatic model(input int w, input int op, input longint a, input longint b,
                       output longint r, output longint c);
    longint mask;
    longint s;
    int     amt;
    mask = (longint'(1) << w) - 1;
    amt  = int'(b % w);
    r = 0;
    c = 0;
    case (op)
      0: r = b;
      1: begin s = a + b; r = s & mask; c = s >> w; end
      2: r = a & b;
      3: r = a | b;
      4: begin r = (a - b) & mask; c = (a < b) ? 1 : 0; end
      5: r = (a << amt) & mask;
      6: begin
`ifdef ALU_ROTATE_EN
        r = ((a >> amt) | (a << (w - amt))) & mask;
        c = (amt == 0) ? 0 : ((a >> (amt - 1)) & 1);
`else
        r = a >> amt;
`endif
      end
      default: begin s = a * b; r = s & mask; c = ((s >> w) != 0) ? 1 : 0; end
    endcase
  endtask

  // Issue one request on the 8-bit unit, scramble the inputs afterwards, wait for done
  task automatic run8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      output int lat);
    @(negedge clk);
    operation = op;
    data1     = a;
    data2     = b;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    data1     = 8'($urandom);
    data2     = 8'($urandom);
    operation = 3'($urandom);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    operation16 = op;
    data1_16    = a;
    data2_16    = b;
    start16     = 1'b1;
    @(posedge clk);
    #1;
    start16     = 1'b0;
  endtask

  initial begin
    int     lat;
    bit     busy_ok;
    bit     seen_done;
    longint er;
    longint ec;
    logic [2:0] rop;
    logic [7:0] ra;
    logic [7:0] rb;

    checks = 0;
    failures = 0;
    reset = 1'b1;
    start = 1'b0;
    data1 = '0;
    data2 = '0;
    operation = '0;
    start16 = 1'b0;
    data1_16 = '0;
    data2_16 = '0;
    operation16 = '0;

    #12;
    check("rst_result", 32'(result), 32'h0);
    check("rst_co", 32'(co), 32'h0);
    check("rst_zero", 32'(zero), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    #5;
    reset = 1'b0;

    // ADD 200+100 followed immediately by FORWARD 4
    @(negedge clk);
    operation = 3'b001; data1 = 8'd200; data2 = 8'd100; start = 1'b1;
    @(posedge clk);
    #1;
    operation = 3'b000; data2 = 8'd4;
    check("add_done", 32'(done), 32'h1);
    check("add_result", 32'(result), 32'd44);
    check("add_co", 32'(co), 32'h1);
    check("add_zero", 32'(zero), 32'h0);
    @(posedge clk);
    #1;
    start = 1'b0;
    check("fwd_done", 32'(done), 32'h1);
    check("fwd_result", 32'(result), 32'd4);
    check("fwd_co", 32'(co), 32'h0);
    @(posedge clk);
    #1;
    check("fwd_done_drop", 32'(done), 32'h0);
    check("fwd_hold", 32'(result), 32'd4);

    // SUB with borrow, then SUB to zero
    run8(3'b100, 8'd3, 8'd4, lat);
    check("sub_lat", 32'(lat), 32'd0);
    check("sub_borrow_result", 32'(result), 32'd255);
    check("sub_borrow_co", 32'(co), 32'h1);
    run8(3'b100, 8'd4, 8'd4, lat);
    check("sub_zero_result", 32'(result), 32'd0);
    check("sub_zero_co", 32'(co), 32'h0);
    check("sub_zero_flag", 32'(zero), 32'h1);

    // Shifts: upper bits of data2 ignored
    run8(3'b101, 8'h81, 8'h09, lat);
    check("sll_result", 32'(result), 32'h02);
    check("sll_co", 32'(co), 32'h0);
    run8(3'b110, 8'h81, 8'h01, lat);
`ifdef ALU_ROTATE_EN
    check("srl_result", 32'(result), 32'hC0);
    check("srl_co", 32'(co), 32'h1);
`else
    check("srl_result", 32'(result), 32'h40);
    check("srl_co", 32'(co), 32'h0);
`endif

    // MUL 12*11 with an ignored ADD start while busy
    @(negedge clk);
    operation = 3'b111; data1 = 8'd12; data2 = 8'd11; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == 3) begin
        start = 1'b1; operation = 3'b001; data1 = 8'd1; data2 = 8'd1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    check("mul_latency", 32'(lat), 32'd8);
    check("mul_busy_held", 32'(busy_ok), 32'h1);
    check("mul_busy_clear", 32'(busy), 32'h0);
    check("mul_result", 32'(result), 32'd132);
    check("mul_co", 32'(co), 32'h0);
    @(posedge clk);
    #1;
    check("mul_ignored_done", 32'(done), 32'h0);
    check("mul_ignored_result", 32'(result), 32'd132);

    run8(3'b111, 8'd20, 8'd20, lat);
    check("mul_ovf_result", 32'(result), 32'd144);
    check("mul_ovf_co", 32'(co), 32'h1);

    // Zero operand still takes full latency
    run8(3'b111, 8'd0, 8'd77, lat);
    check("mul_zero_lat", 32'(lat), 32'd8);
    check("mul_zero_flag", 32'(zero), 32'h1);

    // Start in the done cycle after MUL is accepted
    run8(3'b111, 8'd3, 8'd5, lat);
    check("mul_3x5", 32'(result), 32'd15);
    operation = 3'b001; data1 = 8'd1; data2 = 8'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_cycle_accept_done", 32'(done), 32'h1);
    check("done_cycle_accept_result", 32'(result), 32'd3);

    // Async reset in the middle of MUL 15*15
    @(negedge clk);
    operation = 3'b111; data1 = 8'd15; data2 = 8'd15; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_result", 32'(result), 32'h0);
    check("midrst_co", 32'(co), 32'h0);
    check("midrst_zero", 32'(zero), 32'h0);
    #3;
    reset = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("midrst_no_done", 32'(seen_done), 32'h0);

    // 16-bit AND / OR
    run16(3'b010, 16'hF0F0, 16'h0FF0);
    check("and16_done", 32'(done16), 32'h1);
    check("and16_result", 32'(result16), 32'h00F0);
    check("and16_zero", 32'(zero16), 32'h0);
    run16(3'b011, 16'h0000, 16'h0000);
    check("or16_result", 32'(result16), 32'h0);
    check("or16_zero", 32'(zero16), 32'h1);

    // Randomized operations against the reference model
    for (int n = 0; n < 150; n++) begin
      rop = 3'($urandom);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      if (n % 10 == 0) rb = 8'($urandom_range(0, 1));
      model(8, int'(rop), longint'(ra), longint'(rb), er, ec);
      run8(rop, ra, rb, lat);
      check($sformatf("rnd%0d_op%0d_lat", n, rop), 32'(lat), (rop == 3'b111) ? 32'd8 : 32'd0);
      check($sformatf("rnd%0d_op%0d_result", n, rop), 32'(result), 32'(er));
      check($sformatf("rnd%0d_op%0d_co", n, rop), 32'(co), 32'(ec));
      check($sformatf("rnd%0d_op%0d_zero", n, rop), 32'(zero), (er == 0) ? 32'h1 : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
Parametrised, registered multi-cycle ALU: the next generation of the processor's combinational ALU.
- Keeps the existing opcodes 000–011 and adds SUB, shift and an iterative shift-add multiply.
- Adds a start/busy/done handshake plus carry and zero flags.
- Sits between the register file read stage and writeback; the control unit holds the pipeline while busy is high.

Parameters:
WIDTH, 8, operand/result width in bits (>=4, power of two).
SHW, $clog2(WIDTH), shift-amount field width; derived, do not override.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; accepted on a clk edge when start=1 and busy=0
data1  input  WIDTH  operand A
data2  input  WIDTH  operand B
operation  input  3  opcode, sampled at acceptance
result  output  WIDTH  registered result; held until the next completion
co  output  1  registered carry/borrow/overflow flag
zero  output  1  registered, 1 when result==0
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse when result/co/zero update

Behaviour:
- Reset (async, any time, including mid-multiply):
  - result=0, co=0, zero=0, done=0, busy=0.
  - State returns to IDLE; the in-flight multiply is discarded with no done pulse.
- States: IDLE, MUL.
  - IDLE --accept, op=111--> MUL.
  - MUL --iteration counter reaches WIDTH-1--> IDLE.
- Operand capture: data1, data2 and operation are latched at acceptance. Later input changes do not affect the operation in flight.
- Single-cycle ops (000–110): result, co and zero are written on the acceptance edge; done=1 for the following cycle; busy stays 0.
  - Back-to-back starts give one result per cycle, with done high continuously.
- Opcodes:
  - 000 FORWARD: result=data2, co=0.
  - 001 ADD: {co,result}=data1+data2 (WIDTH+1-bit sum).
  - 010 AND: result=data1&data2, co=0.
  - 011 OR: result=data1|data2, co=0.
  - 100 SUB: result=data1-data2 mod 2^WIDTH; co=1 iff data1<data2 unsigned (borrow).
  - 101 SLL: result=data1<<data2[SHW-1:0]; upper bits of data2 ignored; co=0.
  - 110 SRL: result=data1>>data2[SHW-1:0] logical; co=0 (see optional feature).
  - 111 MUL: unsigned shift-add, one multiplier bit per cycle over 2*WIDTH-bit internal accumulator.
    - busy=1 from the cycle after acceptance until completion.
    - Final write on the WIDTH-th edge after acceptance; done pulses the next cycle, busy=0 in the same cycle.
    - result = low WIDTH bits of the product; co=1 iff the high WIDTH bits are nonzero (overflow).
- zero is computed from the value written to result, on every completion.
- Handshake:
  - start while busy=1 is ignored (not queued).
  - A start in the same cycle that done pulses after MUL is accepted normally.
- Operation 111 with data1=0 or data2=0 still takes the full WIDTH cycles. Latency is fixed, not data-dependent.
- Outputs never change except on a completion or reset.

Optional Feature:
ALU_ROTATE_EN.
- Defined: opcode 110 performs rotate-right of data1 by data2[SHW-1:0]; co = last bit rotated out (bit data2[SHW-1:0]-1 of data1), or 0 when the amount is 0.
- Undefined: opcode 110 is a logical right shift with co=0.
- Opcodes 000–101 and 111 are identical either way.

Test Plan:
- Reset asserted mid-MUL (data1=15, data2=15, reset at cycle 3) -> busy=0, result=0, co=0, zero=0 immediately (async); no done pulse afterwards.
- WIDTH=8 ADD 200+100, then FORWARD data2=4 on the next cycle -> done for two consecutive cycles; first result=44, co=1, zero=0; then result=4, co=0.
- WIDTH=8 SUB 3-4, then SUB 4-4 -> result=255, co=1; then result=0, co=0, zero=1.
- WIDTH=8 MUL 12*11 -> busy high for 8 cycles, done 8 cycles after acceptance, result=132, co=0. MUL 20*20 -> result=144, co=1.
  - start pulsed during busy with op=001 -> ignored; result stays 132.
- WIDTH=8 SLL data1=8'h81, data2=8'h09 (amount 1) -> result=8'h02.
  - Opcode 110, data1=8'h81, amount 1 -> result=8'h40, co=0 without ALU_ROTATE_EN; result=8'hC0, co=1 with it.
- WIDTH=16 AND/OR: 16'hF0F0 & 16'h0FF0 -> 16'h00F0, zero=0; 16'h0000 | 16'h0000 -> 0, zero=1.
